// File: rtl/ahb_pkg.sv
// Shared AHB transfer types and arbitration constants.
package ahb_pkg;

    localparam int unsigned HTRANS_W = 2;

    typedef enum logic [HTRANS_W-1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } htrans_state_t;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam logic ARB_MODE_FIXED = 1'b0;
    localparam logic ARB_MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Combinational requester selection: first candidate from start (round-robin) or from index 0 (fixed).
module rr_pick
    import ahb_pkg::*;
#(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    input  logic [N-1:0]     excl,
    input  logic             mode,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    localparam int unsigned SUM_W = IDX_W + 1;

    logic [N-1:0]     cand_c;
    logic [SUM_W-1:0] pos_c;

    assign cand_c = req & ~excl;

    // Walk candidates in priority order; the first hit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos_c = '0;
        for (int k = 0; k < N; k++) begin
            if (mode == ARB_MODE_RR) begin
                pos_c = SUM_W'(start) + SUM_W'(k);
                if (pos_c >= SUM_W'(N)) begin
                    pos_c = pos_c - SUM_W'(N);
                end
            end else begin
                pos_c = SUM_W'(k);
            end
            if (!found && cand_c[pos_c[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = pos_c[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/ahb_master_arbiter.sv
// AHB master arbiter: per-master pending tracking, non-preemptive fixed/round-robin
// grant with zero-bubble handover, and a grant-hold timeout pulse.
module ahb_master_arbiter
    import ahb_pkg::*;
#(
    parameter int unsigned N_MASTERS = 3,
    parameter int unsigned RR_MODE   = 1,
    parameter int unsigned MAX_HOLD  = 0
) (
    input  logic                           HCLK,
    input  logic                           HRESETn,
    input  logic [N_MASTERS-1:0]           slave_done,
    input  htrans_state_t [N_MASTERS-1:0]  HTRANS,
    output logic [N_MASTERS-1:0]           HREADY,
    output logic                           grant_valid,
    output logic [$clog2(N_MASTERS)-1:0]   grant_idx,
    output logic                           hold_timeout
);

    localparam int unsigned      IDX_W     = $clog2(N_MASTERS);
    localparam int unsigned      HC_W      = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HC_W-1:0]  HOLD_MAX  = HC_W'(MAX_HOLD);
    localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(N_MASTERS - 1);
    localparam logic             PICK_MODE = (RR_MODE != 0) ? ARB_MODE_RR : ARB_MODE_FIXED;

    arb_state_t           state_q, state_d;
    logic [N_MASTERS-1:0] pending_q, pending_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]     last_idx_q, last_idx_d;
    logic [HC_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic                 grant_valid_q, grant_valid_d;
    logic                 hold_timeout_q, hold_timeout_d;

    logic [N_MASTERS-1:0] excl_c;
    logic [IDX_W-1:0]     start_c;
    logic [IDX_W-1:0]     pick_idx_c;
    logic                 pick_found_c;
    logic                 take_c;

    // The outgoing master never re-wins its own handover.
    assign excl_c  = (state_q == ARB_GRANT) ? grant_q : '0;
    assign start_c = (last_idx_q == LAST_RST) ? '0 : last_idx_q + IDX_W'(1);

    rr_pick #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (pending_q),
        .start (start_c),
        .excl  (excl_c),
        .mode  (PICK_MODE),
        .found (pick_found_c),
        .idx   (pick_idx_c)
    );

    // Done beats a simultaneous NONSEQ; only NONSEQ can raise a request.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (slave_done[i]) begin
                pending_d[i] = 1'b0;
            end else if (HTRANS[i] == NONSEQ) begin
                pending_d[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        grant_idx_d    = grant_idx_q;
        last_idx_d     = last_idx_q;
        hold_cnt_d     = '0;
        hold_timeout_d = 1'b0;
        take_c         = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                take_c = pick_found_c;
            end
            ARB_GRANT: begin
                if (pending_q[grant_idx_q]) begin
                    hold_cnt_d     = (hold_cnt_q != HOLD_MAX) ? hold_cnt_q + HC_W'(1) : hold_cnt_q;
                    hold_timeout_d = (MAX_HOLD != 0) && (hold_cnt_q == HC_W'(MAX_HOLD - 1));
                end else if (pick_found_c) begin
                    take_c = 1'b1;
                end else begin
                    state_d     = ARB_IDLE;
                    grant_d     = '0;
                    grant_idx_d = '0;
                end
            end
            default: begin
                state_d     = ARB_IDLE;
                grant_d     = '0;
                grant_idx_d = '0;
            end
        endcase

        if (take_c) begin
            state_d             = ARB_GRANT;
            grant_d             = '0;
            grant_d[pick_idx_c] = 1'b1;
            grant_idx_d         = pick_idx_c;
            last_idx_d          = pick_idx_c;
        end

        grant_valid_d = |grant_d;
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q        <= ARB_IDLE;
            pending_q      <= '0;
            grant_q        <= '0;
            grant_idx_q    <= '0;
            last_idx_q     <= LAST_RST;
            hold_cnt_q     <= '0;
            grant_valid_q  <= 1'b0;
            hold_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            grant_q        <= grant_d;
            grant_idx_q    <= grant_idx_d;
            last_idx_q     <= last_idx_d;
            hold_cnt_q     <= hold_cnt_d;
            grant_valid_q  <= grant_valid_d;
            hold_timeout_q <= hold_timeout_d;
        end
    end

    assign HREADY       = grant_q;
    assign grant_valid  = grant_valid_q;
    assign grant_idx    = grant_idx_q;
    assign hold_timeout = hold_timeout_q;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Scoreboard bench: directed stimulus pushes per-cycle expected grant state; a monitor compares.
module tb_ahb_master_arbiter;
    import ahb_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    htrans_state_t [2:0] htrans_a, htrans_b;
    logic [2:0]          done_a, done_b;
    logic [2:0]          hr_a, hr_b;
    logic                gv_a, gv_b, to_a, to_b;
    logic [1:0]          gi_a, gi_b;

    ahb_master_arbiter #(.N_MASTERS(3), .RR_MODE(1), .MAX_HOLD(4)) dut_rr (
        .HCLK(clk), .HRESETn(rst_n), .slave_done(done_a), .HTRANS(htrans_a),
        .HREADY(hr_a), .grant_valid(gv_a), .grant_idx(gi_a), .hold_timeout(to_a)
    );

    ahb_master_arbiter #(.N_MASTERS(3), .RR_MODE(0), .MAX_HOLD(0)) dut_fp (
        .HCLK(clk), .HRESETn(rst_n), .slave_done(done_b), .HTRANS(htrans_b),
        .HREADY(hr_b), .grant_valid(gv_b), .grant_idx(gi_b), .hold_timeout(to_b)
    );

    typedef struct {
        int         cyc;
        int         dut;
        logic [2:0] hr;
        logic       tmo;
    } exp_t;

    typedef struct {
        int         off;
        logic [2:0] ns;
        logic [2:0] dn;
        logic [2:0] sq;
        logic [2:0] bz;
    } stim_t;

    exp_t  sb[$];
    stim_t stim_q[$];
    int    cyc = 0;
    int    n_checks = 0;
    int    n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [1:0] idx_of(input logic [2:0] v);
        idx_of = 2'd0;
        for (int i = 2; i >= 0; i--) if (v[i]) idx_of = 2'(i);
    endfunction

    function automatic void check_entry(input exp_t e);
        logic [2:0] hr;
        logic       gv, to;
        logic [1:0] gi;
        if (e.dut == 0) begin
            hr = hr_a; gv = gv_a; gi = gi_a; to = to_a;
        end else begin
            hr = hr_b; gv = gv_b; gi = gi_b; to = to_b;
        end
        n_checks++;
        if (hr !== e.hr || gv !== (|e.hr) || gi !== idx_of(e.hr) || to !== e.tmo) begin
            n_fail++;
            $display("FAIL grant_dut%0d cyc=%0d: got HREADY=%b valid=%b idx=%0d timeout=%b, want HREADY=%b valid=%b idx=%0d timeout=%b",
                     e.dut, e.cyc, hr, gv, gi, to, e.hr, |e.hr, idx_of(e.hr), e.tmo);
        end
    endfunction

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        for (int k = sb.size() - 1; k >= 0; k--) begin
            if (sb[k].cyc == cyc) begin
                check_entry(sb[k]);
                sb.delete(k);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_span(input int dut, input int from, input int to, input logic [2:0] hr, input int tmo_at);
        for (int c = from; c <= to; c++) begin
            exp_t e;
            e.cyc = c; e.dut = dut; e.hr = hr; e.tmo = (c == tmo_at);
            sb.push_back(e);
        end
    endtask

    function automatic void add_stim(input int off, input logic [2:0] ns, input logic [2:0] dn,
                                     input logic [2:0] sq = 3'b000, input logic [2:0] bz = 3'b000);
        stim_t s;
        s.off = off; s.ns = ns; s.dn = dn; s.sq = sq; s.bz = bz;
        stim_q.push_back(s);
    endfunction

    task automatic drive(input int dut, input logic [2:0] ns, input logic [2:0] dn,
                         input logic [2:0] sq, input logic [2:0] bz);
        htrans_state_t t [3];
        for (int i = 0; i < 3; i++) begin
            t[i] = ns[i] ? NONSEQ : (sq[i] ? SEQ : (bz[i] ? BUSY : IDLE));
        end
        for (int i = 0; i < 3; i++) begin
            if (dut == 0) htrans_a[i] = t[i];
            else          htrans_b[i] = t[i];
        end
        if (dut == 0) done_a = dn;
        else          done_b = dn;
    endtask

    task automatic run(input int dut, input int len);
        for (int o = 0; o < len; o++) begin
            stim_t s;
            s.off = o; s.ns = 3'b000; s.dn = 3'b000; s.sq = 3'b000; s.bz = 3'b000;
            foreach (stim_q[k]) if (stim_q[k].off == o) s = stim_q[k];
            drive(dut, s.ns, s.dn, s.sq, s.bz);
            tick(1);
        end
        drive(dut, 3'b000, 3'b000, 3'b000, 3'b000);
        stim_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 3'b000, 3'b000, 3'b000, 3'b000);
        drive(1, 3'b000, 3'b000, 3'b000, 3'b000);
        tick(2);
        expect_span(0, cyc, cyc + 1, 3'b000, -1);
        expect_span(1, cyc, cyc + 1, 3'b000, -1);
        rst_n = 1'b1;
        tick(2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        do_reset();

        // Single request on master 1: grant from +2, done at +5 drops grant at +7.
        b = cyc;
        expect_span(0, b, b + 1, 3'b000, -1);
        expect_span(0, b + 2, b + 6, 3'b010, b + 6);
        expect_span(0, b + 7, b + 9, 3'b000, -1);
        add_stim(0, 3'b010, 3'b000);
        add_stim(5, 3'b000, 3'b010);
        run(0, 10);

        // Round-robin picks 2 over 0 when handing over from master 1.
        b = cyc;
        expect_span(0, b, b + 1, 3'b000, -1);
        expect_span(0, b + 2, b + 4, 3'b001, -1);
        expect_span(0, b + 5, b + 7, 3'b010, -1);
        expect_span(0, b + 8, b + 10, 3'b100, -1);
        expect_span(0, b + 11, b + 13, 3'b001, -1);
        expect_span(0, b + 14, b + 15, 3'b000, -1);
        add_stim(0, 3'b011, 3'b000);
        add_stim(3, 3'b000, 3'b001);
        add_stim(5, 3'b101, 3'b000);
        add_stim(6, 3'b000, 3'b010);
        add_stim(9, 3'b000, 3'b100);
        add_stim(12, 3'b000, 3'b001);
        run(0, 16);

        // Fairness from reset: two rounds of 0,1,2 with back-to-back handover.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            b = cyc;
            expect_span(0, b, b + 1, 3'b000, -1);
            expect_span(0, b + 2, b + 6, 3'b001, b + 6);
            expect_span(0, b + 7, b + 11, 3'b010, b + 11);
            expect_span(0, b + 12, b + 16, 3'b100, b + 16);
            add_stim(0, 3'b111, 3'b000);
            add_stim(5, 3'b000, 3'b001);
            add_stim(10, 3'b000, 3'b010);
            add_stim(15, 3'b000, 3'b100);
            run(0, 17);
        end

        // Done with NONSEQ together, then SEQ/BUSY only: no request may form.
        b = cyc;
        expect_span(0, b, b + 5, 3'b000, -1);
        add_stim(0, 3'b001, 3'b001);
        add_stim(1, 3'b000, 3'b000, 3'b011, 3'b100);
        add_stim(2, 3'b000, 3'b000, 3'b100, 3'b011);
        run(0, 6);

        // Hold timeout: master 2 never done, one pulse 4 cycles into the grant.
        do_reset();
        b = cyc;
        expect_span(0, b, b + 1, 3'b000, -1);
        expect_span(0, b + 2, b + 12, 3'b100, b + 6);
        add_stim(0, 3'b100, 3'b000);
        add_stim(4, 3'b100, 3'b000);
        run(0, 13);

        // Reset during master 1 grant with master 0 pending.
        do_reset();
        b = cyc;
        expect_span(0, b, b + 1, 3'b000, -1);
        expect_span(0, b + 2, b + 4, 3'b010, -1);
        expect_span(0, b + 5, b + 10, 3'b000, -1);
        add_stim(0, 3'b010, 3'b000);
        add_stim(2, 3'b001, 3'b000);
        run(0, 4);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        run(0, 6);

        // Fixed priority: lowest pending index wins whenever master 0 competes.
        do_reset();
        b = cyc;
        expect_span(1, b, b + 1, 3'b000, -1);
        expect_span(1, b + 2, b + 4, 3'b001, -1);
        expect_span(1, b + 5, b + 6, 3'b000, -1);
        expect_span(1, b + 7, b + 9, 3'b001, -1);
        expect_span(1, b + 10, b + 12, 3'b010, -1);
        expect_span(1, b + 13, b + 15, 3'b001, -1);
        expect_span(1, b + 16, b + 18, 3'b100, -1);
        expect_span(1, b + 19, b + 21, 3'b000, -1);
        add_stim(0, 3'b001, 3'b000);
        add_stim(3, 3'b000, 3'b001);
        add_stim(5, 3'b101, 3'b000);
        add_stim(7, 3'b010, 3'b000);
        add_stim(8, 3'b000, 3'b001);
        add_stim(9, 3'b001, 3'b000);
        add_stim(11, 3'b000, 3'b010);
        add_stim(14, 3'b000, 3'b001);
        add_stim(17, 3'b000, 3'b100);
        run(1, 22);

        tick(2);
        foreach (sb[k]) begin
            n_checks++;
            n_fail++;
            $display("FAIL unchecked_dut%0d cyc=%0d: expectation never compared, want HREADY=%b", sb[k].dut, sb[k].cyc, sb[k].hr);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_master_arbiter.md
AHB_MASTER_ARBITER -- requirements
Module: ahb_master_arbiter

Interface
REQ-001 SHALL have parameter N_MASTERS, default 3: number of requesting masters, legal range 2..8.
REQ-002 SHALL have parameter RR_MODE, default 1: 1 = round-robin arbitration, 0 = fixed priority with index 0 highest.
REQ-003 SHALL have parameter MAX_HOLD, default 0: grant-hold cycle limit for timeout reporting; 0 disables timeout.
REQ-004 SHALL have one clock; reset is synchronous and active-low.
REQ-005 SHALL have port HCLK, input, 1 bit: the clock; all state updates on its rising edge.
REQ-006 SHALL have port HRESETn, input, 1 bit: synchronous active-low reset.
REQ-007 SHALL have port slave_done, input, N_MASTERS bits: bit i pulses high when master i's slave transaction completes.
REQ-008 SHALL have port HTRANS, input, N_MASTERS x HTRANS_state: transfer type per master.
REQ-009 SHALL have port HREADY, output, N_MASTERS bits: one-hot or all-zero grant vector; bit i high means master i is granted.
REQ-010 SHALL have port grant_valid, output, 1 bit: OR of HREADY.
REQ-011 SHALL have port grant_idx, output, $clog2(N_MASTERS) bits: index of the granted master; 0 when grant_valid is 0.
REQ-012 SHALL have port hold_timeout, output, 1 bit: single-cycle pulse when the current grant reaches MAX_HOLD cycles.

Function
REQ-013 SHALL keep a pending register, pending[i], per master.
REQ-014 pending[i] SHALL clear when slave_done[i]=1; done SHALL win over a simultaneous NONSEQ.
REQ-015 Otherwise, pending[i] SHALL set when HTRANS[i]==NONSEQ and pending[i]==0.
REQ-016 Otherwise, pending[i] SHALL hold; NONSEQ while already pending SHALL be ignored, and IDLE, BUSY and SEQ SHALL never set pending.
REQ-017 The grant register SHALL be HREADY and SHALL never have more than one bit set.
REQ-018 Idle state (no grant): the next cycle SHALL grant the master selected from pending by the arbitration rule; it SHALL stay idle if none is pending.
REQ-019 Granted state, granted master still pending: the grant SHALL hold unchanged and SHALL never be preempted.
REQ-020 Granted state, granted master's pending==0: in that same edge the arbiter SHALL clear the current grant and set the grant for the selected other pending master, or go idle if none; there SHALL be no idle bubble.
REQ-021 Fixed priority: selection SHALL be the lowest pending index.
REQ-022 Round-robin: selection SHALL be the first pending index searching last_idx+1, last_idx+2, … with wrap modulo N_MASTERS.
REQ-023 last_idx SHALL update to the new index on every new grant.
REQ-024 In the granted-to-other case, the outgoing master SHALL be excluded from selection.
REQ-025 Latency: NONSEQ sampled at edge t sets pending at t; with the arbiter idle, HREADY rises after edge t+1, i.e. 2 cycles.
REQ-026 hold_cnt SHALL reset to 0 on every new grant and when idle.
REQ-027 hold_cnt SHALL increment each cycle a grant is held and saturate at MAX_HOLD.
REQ-028 hold_timeout SHALL pulse for exactly one cycle when hold_cnt reaches MAX_HOLD; the grant SHALL be unaffected.
REQ-029 hold_cnt width SHALL be $clog2(MAX_HOLD+1), minimum 1 bit.

Reset
REQ-030 On HRESETn=0 at an edge: pending=0, HREADY=0, grant_valid=0, grant_idx=0, hold_cnt=0, hold_timeout=0, last_idx=N_MASTERS-1 so master 0 wins first.
REQ-031 Reset mid-grant SHALL drop the grant in the next cycle and discard all pending requests.

Structure
REQ-032 HTRANS_state (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3) SHALL live in shared package ahb_pkg.
REQ-033 Arbitration constants SHALL live in shared package ahb_pkg.
REQ-034 The selection logic SHALL be a combinational sub-module rr_pick, with inputs req vector, start index, exclude mask and mode, and outputs found and idx; it SHALL be reused for both the idle and handover cases.

Verification (N_MASTERS=3 unless stated)
REQ-035 Single request: NONSEQ on master 1 at cycle 0, others IDLE -> HREADY=3'b010 from cycle 2; slave_done[1] at cycle 5 -> HREADY=0 from cycle 7.
REQ-036 Round-robin fairness: all three pending from reset, each done 3 cycles after its grant -> grant order 0,1,2, then on new NONSEQ from all: 0,1,2 again, with handover in 1 cycle and no zero gap.
REQ-037 Fixed priority (RR_MODE=0): masters 0 and 2 pending, master 0 re-requests immediately after each done -> master 2 is never granted while master 0 keeps re-requesting.
REQ-038 Simultaneous done+NONSEQ on master 0 -> pending[0] stays 0; no spurious grant.
REQ-039 Timeout (MAX_HOLD=4): master 2 granted and never done -> hold_timeout high for exactly one cycle, 4 cycles after the grant; HREADY=3'b100 unchanged.
REQ-040 Reset asserted while master 1 is granted with master 0 pending -> all outputs 0 next cycle; after release, no grant without a fresh NONSEQ.
